timetag_encoder: RTL and testbench

//  Stamps the one-cycle edge pulses produced by the per-channel click latches with a free-running

---
 rtl/timetag_encoder.sv | 88 ++++++++
 tb/tb_timetag_encoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/timetag_encoder.sv
// Timestamps per-channel edge pulses and queues tag words {lost, roll, mask, ts}
// in a show-ahead FIFO with valid/ready readout. Idle timestamp wraps emit rollover markers.
module timetag_encoder #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned TS_W  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NCH-1:0]               data_in,
  output logic [TS_W+NCH+1:0]          out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [15:0]                  lost_count
);

  localparam int unsigned W  = TS_W + NCH + 2;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [TS_W-1:0] ts;
  logic            armed;
  logic            lost_flag;
  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;

  logic            roll;
  logic            push;
  logic            pop;
  logic            accept;
  logic [W-1:0]    word;

  // armed masks the ts==0 of the very first cycle after reset, which is not a wrap
  always_comb begin
    roll      = armed && (ts == '0);
    push      = (|data_in) || roll;
    out_valid = (level != '0);
    pop       = out_valid && out_ready;
    accept    = push && ((level != LW'(DEPTH)) || pop);
    word      = {lost_flag, roll, data_in, ts};
    out_data  = mem[rd_ptr];
  end

  assign fifo_level = level;

  always_ff @(posedge clock) begin
    if (reset) begin
      ts         <= '0;
      armed      <= 1'b0;
      lost_flag  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      lost_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ts    <= ts + TS_W'(1);
      armed <= 1'b1;

      if (accept) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + AW'(1);
        lost_flag   <= 1'b0;
      end else if (push) begin
        lost_flag <= 1'b1;
        if (lost_count != '1) begin
          lost_count <= lost_count + 16'd1;
        end
      end

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_timetag_encoder.sv
// Directed bench for timetag_encoder (NCH=4, TS_W=8, DEPTH=4): a reference queue
// of expected tag words is filled as pulses are driven and drained as the DUT pops.
module tb_timetag_encoder;

  localparam int unsigned NCH   = 4;
  localparam int unsigned TS_W  = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = TS_W + NCH + 2;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic            clock;
  logic            reset;
  logic [NCH-1:0]  data_in;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [LW-1:0]   fifo_level;
  logic [15:0]     lost_count;

  timetag_encoder #(.NCH(NCH), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .lost_count (lost_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // reference state
  logic [W-1:0]    sb [$];
  logic [TS_W-1:0] mts;
  logic            marmed;
  logic            mlost;
  int              mlcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mts    = '0;
    marmed = 1'b0;
    mlost  = 1'b0;
    mlcnt  = 0;
  endtask

  // Positioned at a negedge: check outputs against the reference, drive the
  // next cycle's inputs, advance the reference, then move to the next negedge.
  task automatic step(input logic [NCH-1:0] din, input logic rdy);
    logic roll, push, pop, acc;
    chk("valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("level", 32'(fifo_level), 32'(sb.size()));
    chk("lost_count", 32'(lost_count), 32'(mlcnt));
    if (sb.size() != 0) chk("head_word", 32'(out_data), 32'(sb[0]));
    data_in   = din;
    out_ready = rdy;
    roll = marmed && (mts == 0);
    push = (din != 0) || roll;
    pop  = (sb.size() != 0) && rdy;
    acc  = push && ((sb.size() < DEPTH) || pop);
    if (pop) void'(sb.pop_front());
    if (acc) begin
      sb.push_back({mlost, roll, din, mts});
      mlost = 1'b0;
    end else if (push) begin
      mlost = 1'b1;
      if (mlcnt < 16'hFFFF) mlcnt++;
    end
    mts    = mts + 8'd1;
    marmed = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    data_in   = '0;
    out_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_lost", 32'(lost_count), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    data_in   = '0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clock);
    do_reset();

    // single pulse at ts=5, one-cycle latency, drained next cycle
    repeat (5) step('0, 1'b1);
    step(4'b0001, 1'b1);
    chk("first_word", 32'(out_data), 32'h105);
    chk("first_valid", 32'(out_valid), 32'd1);
    step('0, 1'b1);
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_level", 32'(fifo_level), 32'd0);

    // coincident channels at ts=9 -> one word
    repeat (2) step('0, 1'b1);
    step(4'b1010, 1'b1);
    chk("multi_word", 32'(out_data), 32'h0A09);
    step('0, 1'b1);
    chk("multi_lost", 32'(lost_count), 32'd0);

    // idle through first wrap: one marker at ts=0
    while (mts != 8'd0) step('0, 1'b1);
    step('0, 1'b1);
    chk("marker", 32'(out_data), 32'h1000);
    chk("marker_valid", 32'(out_valid), 32'd1);

    // pulse exactly on the next wrap -> single word with roll
    while (mts != 8'd0) step('0, 1'b1);
    step(4'b0100, 1'b1);
    chk("wrap_pulse", 32'(out_data), 32'h1400);
    step('0, 1'b1);
    chk("wrap_single", 32'(fifo_level), 32'd0);

    // overflow: 6 pulses with no readout
    do_reset();
    for (int i = 0; i < 6; i++) step(NCH'(i + 1), 1'b0);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_lost", 32'(lost_count), 32'd2);
    // full + pop + push: accepted, level stays 4, carries lost bit
    step(4'b1000, 1'b1);
    chk("fpp_level", 32'(fifo_level), 32'd4);
    chk("fpp_lost", 32'(lost_count), 32'd2);
    step(4'b0110, 1'b1);
    repeat (6) step('0, 1'b1);
    chk("ovf_empty", 32'(fifo_level), 32'd0);

    // reset with words queued
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b0);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    do_reset();
    step(4'b0010, 1'b1);
    chk("post_rst_ts0", 32'(out_data), 32'h0200);
    repeat (3) step('0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
